serial_paralelo_rx: RTL and testbench
=====================================

# serial_paralelo_rx

Receive-side serial-to-parallel converter for the PHY lane, clocked by `clk_32f`, the fastest clock of the design; `clk_gen` derives `clk_f`, `clk_2f` and `clk_4f` from the same source. The block shifts in one serial bit per `clk_32f` cycle and hunts for the COM symbol (0xBC) at any bit offset. It locks byte alignment after `BC_COUNT` consecutive aligned COM symbols, then delivers one byte every 8 cycles to the downstream byte un-striping stage, which runs at `clk_4f`.

## Interface
Parameters:
- `COMMA`, 8'hBC: alignment/idle symbol.
- `BC_COUNT`, 4: consecutive aligned COM symbols required to enter ACTIVE; legal range 1..15.

Ports:
- `clk_32f`  input  1  sole clock, rising-edge.
- `reset`  input  1  synchronous, active-low; sampled on `clk_32f` rising edge.
- `data_in`  input  1  serial bit, MSB first, one bit per cycle.
- `data_out`  output  8  last completed aligned byte.
- `valid_out`  output  1  `data_out` holds a non-COMMA byte received while ACTIVE.
- `byte_strobe`  output  1  one-cycle pulse marking a byte boundary while ACTIVE.
- `active`  output  1  alignment locked.

## Operation
- Internal registers:
  - `shreg[7:0]`, updated every cycle as `shreg <= {shreg[6:0], data_in}`.
  - Byte window `win = {shreg[6:0], data_in}`: the 8 most recent bits including the current sample.
  - `bitcnt[2:0]`.
  - `bc_cnt[3:0]`.
  - State machine with states SEARCH, ALIGN, ACTIVE.
- Reset (`reset`==0 at an edge): state=SEARCH, `shreg`=0, `bitcnt`=0, `bc_cnt`=0.
  - Output reset values: `data_out`=8'h00, `valid_out`=0, `byte_strobe`=0, `active`=0.
  - Reset has priority over every other event, in any state, including mid-byte.
- SEARCH:
  - `win` is compared every cycle (sliding, any bit offset).
  - `win`==COMMA: `bitcnt`<=0, `bc_cnt`<=1. If `BC_COUNT`==1, go to ACTIVE (same rules as the ALIGN→ACTIVE transition below); otherwise go to ALIGN.
  - Otherwise remain in SEARCH.
- ALIGN:
  - `bitcnt` increments every cycle and wraps 7→0.
  - `win` is evaluated only when `bitcnt`==7.
  - `win`==COMMA and `bc_cnt`+1==`BC_COUNT`: go to ACTIVE; `active`<=1.
  - `win`==COMMA otherwise: `bc_cnt`<=`bc_cnt`+1.
  - `win`!=COMMA: go to SEARCH, `bc_cnt`<=0.
  - No sliding comparison inside ALIGN: a COMMA straddling the locked boundary is not recognised.
- ACTIVE:
  - `bitcnt` keeps wrapping.
  - At `bitcnt`==7: `data_out`<=`win`, `byte_strobe`<=1, `valid_out`<=(`win`!=COMMA).
  - At all other counts: `byte_strobe`<=0; `data_out` and `valid_out` hold.
  - ACTIVE is left only by reset. A non-COMMA byte or a misaligned stream does not drop lock.
- `data_out`, `valid_out` and `byte_strobe` change only in ACTIVE; in SEARCH/ALIGN they keep their reset values.

## Timing
- All outputs are registered.
- Byte latency: the 8th bit of a byte is sampled at edge N; `data_out`, `valid_out` and `byte_strobe` reflect that byte after edge N.
- `byte_strobe` is high for exactly 1 of every 8 cycles in ACTIVE, with period 8 exactly.
- `active` rises after the edge that samples the last bit of the `BC_COUNT`-th COMMA. No byte output is produced for that COMMA.
- Minimum lock time from reset release: 8·`BC_COUNT` cycles of input.
- A byte completing in the same cycle reset is asserted is discarded.
- Downstream stage samples `data_out`/`valid_out` on `clk_4f`. Values are stable for 8 `clk_32f` cycles, i.e. one full `clk_4f` period.

## Test plan
- Reset hold: drive `reset`=0 for 10 cycles with random `data_in` -> `data_out`=00, `valid_out`=0, `byte_strobe`=0, `active`=0 throughout.
- Lock at offset 3: 3 junk bits, then BC,BC,BC,BC, then 0x5A,0x3C (MSB first) -> `active` rises after the 35th bit. Strobes after the 43rd and 51st bits, with `data_out`=5A then 3C and `valid_out`=1 for each.
- Broken alignment: BC,BC,0x11,BC,BC,BC,BC -> no lock after the 0x11 byte; `active` rises only after the 7th byte, with `bc_cnt` restarting at the 4th byte.
- Idle in ACTIVE: after lock, send BC,0xA5,BC -> strobes with `data_out`=BC/`valid_out`=0, then A5/1, then BC/0; `active` stays 1.
- Reset mid-operation: in ACTIVE, assert `reset`=0 at bit 4 of a byte for 1 cycle -> all outputs return to reset values the next cycle. Relock requires 4 fresh COMMAs.
- Parameter `BC_COUNT`=1: a single BC at offset 5 -> `active`=1 after bit 13; the next byte is strobed 8 cycles later.

Source files
------------

// File: rtl/serial_paralelo_rx.sv
// serial_paralelo_rx: serial-to-parallel receiver that hunts for COMMA at any bit offset,
// locks byte alignment after BC_COUNT aligned COMMAs and then emits one byte every 8 cycles.
module serial_paralelo_rx #(
    parameter logic [7:0] COMMA    = 8'hBC,
    parameter int         BC_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);
    typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;
    state_t     state, state_nx;
    logic [7:0] shreg, win, data_nx;
    logic [2:0] bitcnt, bitcnt_nx;
    logic [3:0] bc_cnt, bc_cnt_nx;
    logic       valid_nx, strobe_nx, active_nx, comma;
    assign win   = {shreg[6:0], data_in};
    assign comma = win == COMMA;
    always_comb begin
        state_nx  = state;
        bitcnt_nx = bitcnt + 3'd1;
        bc_cnt_nx = bc_cnt;
        data_nx   = data_out;
        valid_nx  = valid_out;
        strobe_nx = 1'b0;
        active_nx = active;
        case (state)
            SEARCH: if (comma) begin
                bitcnt_nx = 3'd0;
                bc_cnt_nx = 4'd1;
                state_nx  = (BC_COUNT == 1) ? ACTIVE : ALIGN;
                active_nx = BC_COUNT == 1;
            end
            // only the locked boundary is examined; a straddling COMMA is ignored
            ALIGN: if (bitcnt == 3'd7) begin
                if (comma) begin
                    bc_cnt_nx = bc_cnt + 4'd1;
                    if (bc_cnt + 4'd1 == BC_COUNT[3:0]) begin
                        state_nx  = ACTIVE;
                        active_nx = 1'b1;
                    end
                end else begin
                    state_nx  = SEARCH;
                    bc_cnt_nx = 4'd0;
                end
            end
            ACTIVE: if (bitcnt == 3'd7) begin
                data_nx   = win;
                valid_nx  = !comma;
                strobe_nx = 1'b1;
            end
            default: state_nx = SEARCH;
        endcase
    end
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            state       <= SEARCH;
            shreg       <= 8'h00;
            bitcnt      <= 3'd0;
            bc_cnt      <= 4'd0;
            data_out    <= 8'h00;
            valid_out   <= 1'b0;
            byte_strobe <= 1'b0;
            active      <= 1'b0;
        end else begin
            state       <= state_nx;
            shreg       <= win;
            bitcnt      <= bitcnt_nx;
            bc_cnt      <= bc_cnt_nx;
            data_out    <= data_nx;
            valid_out   <= valid_nx;
            byte_strobe <= strobe_nx;
            active      <= active_nx;
        end
    end
endmodule

// File: tb/tb_serial_paralelo_rx.sv
// tb_serial_paralelo_rx: drives two receivers (BC_COUNT 4 and 1) with directed and random
// serial streams and compares every output each cycle against a bit-index based model.
module tb_serial_paralelo_rx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0;
    logic [7:0] dout [2];
    logic       vout [2];
    logic       bs [2];
    logic       act [2];
    int n_vec = 0;
    int n_err = 0;
    int         bcn [2] = '{4, 1};
    int         m_n [2];
    int         m_run [2];
    int         m_anchor [2];
    bit         m_lock [2];
    bit [7:0]   m_hist [2];
    bit [7:0]   e_data [2];
    bit         e_valid [2];
    bit         e_strobe [2];
    always #5 clk = ~clk;
    serial_paralelo_rx #(.COMMA(8'hBC), .BC_COUNT(4)) u0 (
        .clk_32f(clk), .reset(rst_n), .data_in(din),
        .data_out(dout[0]), .valid_out(vout[0]), .byte_strobe(bs[0]), .active(act[0]));
    serial_paralelo_rx #(.COMMA(8'hBC), .BC_COUNT(1)) u1 (
        .clk_32f(clk), .reset(rst_n), .data_in(din),
        .data_out(dout[1]), .valid_out(vout[1]), .byte_strobe(bs[1]), .active(act[1]));
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    // model: n = bits since reset, anchor = bit index ending the first aligned COMMA
    task automatic model_step(input int k, input logic b, input logic r);
        bit [7:0] w;
        bit       edge8;
        if (!r) begin
            m_n[k] = 0; m_run[k] = 0; m_anchor[k] = 0; m_lock[k] = 0; m_hist[k] = 0;
            e_data[k] = 0; e_valid[k] = 0; e_strobe[k] = 0;
            return;
        end
        m_n[k]++;
        w = {m_hist[k][6:0], b};
        m_hist[k] = w;
        edge8 = (m_run[k] > 0 || m_lock[k]) && ((m_n[k] - m_anchor[k]) % 8 == 0);
        if (m_lock[k]) begin
            e_strobe[k] = edge8;
            if (edge8) begin
                e_data[k]  = w;
                e_valid[k] = w != 8'hBC;
            end
        end else if (m_run[k] == 0) begin
            if (w == 8'hBC) begin
                m_run[k] = 1;
                m_anchor[k] = m_n[k];
                m_lock[k] = bcn[k] == 1;
            end
        end else if (edge8) begin
            if (w == 8'hBC) begin
                m_run[k]++;
                m_lock[k] = m_run[k] == bcn[k];
            end else m_run[k] = 0;
        end
    endtask
    task automatic send_bit(input logic b, input logic r);
        din = b;
        rst_n = r;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, b, r);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("u%0d_active", k), act[k], m_lock[k]);
            check($sformatf("u%0d_strobe", k), bs[k], e_strobe[k]);
            check($sformatf("u%0d_data", k), dout[k], e_data[k]);
            check($sformatf("u%0d_valid", k), vout[k], e_valid[k]);
        end
    endtask
    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i], 1'b1);
    endtask
    task automatic expect_byte(input string tag, input logic [7:0] d, input logic v);
        check({tag, "_strobe"}, bs[0], 8'd1);
        check({tag, "_data"}, dout[0], d);
        check({tag, "_valid"}, vout[0], v);
    endtask
    initial begin
        logic [7:0] v;
        for (int i = 0; i < 10; i++) begin
            send_bit(1'($urandom), 1'b0);
            check("rst_hold_act", act[0], 8'd0);
            check("rst_hold_data", dout[0], 8'h00);
        end
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1);
        for (int j = 0; j < 3; j++) send_byte(8'hBC);
        v = 8'hBC;
        for (int i = 7; i >= 1; i--) send_bit(v[i], 1'b1);
        check("lock3_bit34_act", act[0], 8'd0);
        send_bit(v[0], 1'b1);
        check("lock3_bit35_act", act[0], 8'd1);
        check("lock3_no_strobe", bs[0], 8'd0);
        send_byte(8'h5A);
        expect_byte("lock3_b5a", 8'h5A, 1'b1);
        send_byte(8'h3C);
        expect_byte("lock3_b3c", 8'h3C, 1'b1);
        send_byte(8'hBC);
        expect_byte("idle_bc1", 8'hBC, 1'b0);
        send_byte(8'hA5);
        expect_byte("idle_a5", 8'hA5, 1'b1);
        send_byte(8'hBC);
        expect_byte("idle_bc2", 8'hBC, 1'b0);
        check("idle_act", act[0], 8'd1);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom), 1'b1);
        send_bit(1'b1, 1'b0);
        check("midrst_act", act[0], 8'd0);
        check("midrst_data", dout[0], 8'h00);
        check("midrst_strobe", bs[0], 8'd0);
        for (int j = 0; j < 3; j++) send_byte(8'hBC);
        check("relock_3_act", act[0], 8'd0);
        send_byte(8'hBC);
        check("relock_4_act", act[0], 8'd1);
        send_bit(1'b0, 1'b0);
        send_byte(8'hBC); send_byte(8'hBC); send_byte(8'h11);
        check("broken_after11", act[0], 8'd0);
        send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hBC);
        check("broken_6th", act[0], 8'd0);
        send_byte(8'hBC);
        check("broken_7th", act[0], 8'd1);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1);
        v = 8'hBC;
        for (int i = 7; i >= 1; i--) send_bit(v[i], 1'b1);
        check("bc1_bit12_act", act[1], 8'd0);
        send_bit(v[0], 1'b1);
        check("bc1_bit13_act", act[1], 8'd1);
        send_byte(8'h77);
        check("bc1_strobe", bs[1], 8'd1);
        check("bc1_data", dout[1], 8'h77);
        check("bc1_valid", vout[1], 8'd1);
        for (int it = 0; it < 20; it++) begin
            send_bit(1'b0, 1'b0);
            for (int i = 0; i < int'($urandom_range(0, 7)); i++) send_bit(1'($urandom), 1'b1);
            for (int j = 0; j < 30; j++) begin
                v = ($urandom_range(0, 9) < 6) ? 8'hBC : 8'($urandom);
                for (int i = 7; i >= 0; i--) send_bit(v[i], ($urandom_range(0, 199) != 0));
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
